// File: rtl/icache_assoc.sv
// icache_assoc
// Set-associative, read-only instruction cache between the processor fetch
// port and a 128-bit block memory. Each line holds 4 x 32-bit words.
// Replacement is true LRU via per-way ages (0 = most recently used).
// Hits return data combinationally with no stall. Misses take one cycle to
// issue the block read, then return the word in the cycle mem_ready is high.
// Ports:
//   clk, proc_reset           clock, asynchronous active-high reset
//   proc_read, proc_addr      fetch request and word address
//   proc_write, proc_wdata    accepted but ignored (read-only cache)
//   proc_stall, proc_rdata    stall indication and fetched word
//   cache_flush               invalidate every line (honoured in idle only)
//   mem_read, mem_addr        block read request and block address
//   mem_rdata, mem_ready      block data and its valid strobe
//   mem_write, mem_wdata      tied low
//   hit_cnt, miss_cnt         saturating performance counters
module icache_assoc #(
   parameter int NUM_SETS = 4,
   parameter int NUM_WAYS = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              proc_read,
   input  logic              proc_write,
   input  logic [29:0]       proc_addr,
   input  logic [31:0]       proc_wdata,
   output logic              proc_stall,
   output logic [31:0]       proc_rdata,
   input  logic              cache_flush,
   output logic              mem_read,
   output logic              mem_write,
   output logic [27:0]       mem_addr,
   input  logic [127:0]      mem_rdata,
   input  logic              mem_ready,
   output logic [127:0]      mem_wdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_W = 28 - IDX_W;

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_MEM_READ = 1'b1;

   logic [0:0]          r_state;
   logic [NUM_SETS-1:0] r_valid [NUM_WAYS];
   logic [TAG_W-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
   logic [127:0]        r_data  [NUM_WAYS][NUM_SETS];
   logic [AGE_W-1:0]    r_age   [NUM_WAYS][NUM_SETS];
   logic                r_memRead;
   logic [27:0]         r_memAddr;
   logic [31:0]         r_rdata;
   logic [CNT_W-1:0]    r_hitCnt;
   logic [CNT_W-1:0]    r_missCnt;

   logic [1:0]          w_offset;
   logic [IDX_W-1:0]    w_index;
   logic [TAG_W-1:0]    w_tag;
   logic [IDX_W-1:0]    w_fillIdx;
   logic [TAG_W-1:0]    w_fillTag;
   logic                w_hit;
   logic [AGE_W-1:0]    w_hitWay;
   logic [AGE_W-1:0]    w_victim;
   logic                w_foundInvalid;
   logic [31:0]         w_hitWord;
   logic [31:0]         w_fillWord;
   logic                w_doHit;
   logic                w_doMiss;
   logic                w_doFlush;
   logic                w_doFill;
   logic [IDX_W-1:0]    w_touchSet;
   logic [AGE_W-1:0]    w_touchWay;
   logic [AGE_W-1:0]    w_touchOld;
   logic                w_unused;

   assign w_offset  = proc_addr[1:0];
   assign w_index   = proc_addr[IDX_W+1:2];
   assign w_tag     = proc_addr[29:IDX_W+2];

   // The fill target comes from the latched block address, which is the
   // address that was actually requested from memory.
   assign w_fillIdx = r_memAddr[IDX_W-1:0];
   assign w_fillTag = r_memAddr[27:IDX_W];

   assign w_unused  = ^{proc_write, proc_wdata};

   // Tag compare across all ways of the addressed set. At most one way can
   // match because a fill only happens after a miss on that tag.
   always_comb begin
      w_hit    = 1'b0;
      w_hitWay = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
            w_hit    = 1'b1;
            w_hitWay = AGE_W'(w);
         end
      end
   end

   // Victim is the lowest-index invalid way if any, otherwise the oldest way.
   always_comb begin
      w_victim       = '0;
      w_foundInvalid = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_foundInvalid && !r_valid[w][w_fillIdx]) begin
            w_victim       = AGE_W'(w);
            w_foundInvalid = 1'b1;
         end
      end
      if (!w_foundInvalid) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w][w_fillIdx] == AGE_W'(NUM_WAYS - 1)) begin
               w_victim = AGE_W'(w);
            end
         end
      end
   end

   assign w_hitWord  = r_data[w_hitWay][w_index][{w_offset, 5'b0} +: 32];
   assign w_fillWord = mem_rdata[{w_offset, 5'b0} +: 32];

   // Flush outranks a read in idle; the memory state ignores flush entirely.
   assign w_doFlush = (r_state == S_IDLE) && cache_flush;
   assign w_doHit   = (r_state == S_IDLE) && !cache_flush && proc_read && w_hit;
   assign w_doMiss  = (r_state == S_IDLE) && !cache_flush && proc_read && !w_hit;
   assign w_doFill  = (r_state == S_MEM_READ) && mem_ready;

   // The LRU update is identical for a hit and a fill; only the set and the
   // way being promoted to MRU differ.
   assign w_touchSet = w_doFill ? w_fillIdx : w_index;
   assign w_touchWay = w_doFill ? w_victim  : w_hitWay;
   assign w_touchOld = r_age[w_touchWay][w_touchSet];

   // Stall and read data are combinational so hits and fills complete in
   // the same cycle; reset forces both quiet immediately.
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = r_rdata;
      if (proc_reset) begin
         proc_rdata = '0;
      end else if (r_state == S_IDLE) begin
         proc_stall = cache_flush || (proc_read && !w_hit);
         if (w_doHit) begin
            proc_rdata = w_hitWord;
         end
      end else begin
         proc_stall = !mem_ready;
         if (mem_ready) begin
            proc_rdata = w_fillWord;
         end
      end
   end

   // Control state, valid bits, ages, counters and the held read data.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         r_state   <= S_IDLE;
         r_memRead <= 1'b0;
         r_memAddr <= '0;
         r_rdata   <= '0;
         r_hitCnt  <= '0;
         r_missCnt <= '0;
         for (int w = 0; w < NUM_WAYS; w++) begin
            r_valid[w] <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
               r_age[w][s] <= AGE_W'(w);
            end
         end
      end else begin
         if (r_state == S_IDLE) begin
            if (w_doMiss) begin
               r_state   <= S_MEM_READ;
               r_memRead <= 1'b1;
               r_memAddr <= proc_addr[29:2];
               if (r_missCnt != '1) begin
                  r_missCnt <= r_missCnt + CNT_W'(1);
               end
            end
            if (w_doHit) begin
               r_rdata <= w_hitWord;
               if (r_hitCnt != '1) begin
                  r_hitCnt <= r_hitCnt + CNT_W'(1);
               end
            end
         end else if (mem_ready) begin
            r_state   <= S_IDLE;
            r_memRead <= 1'b0;
            r_rdata   <= w_fillWord;
         end

         if (w_doFlush) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               r_valid[w] <= '0;
            end
         end else if (w_doFill) begin
            r_valid[w_victim][w_fillIdx] <= 1'b1;
         end

         if (w_doHit || w_doFill) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (AGE_W'(w) == w_touchWay) begin
                  r_age[w][w_touchSet] <= '0;
               end else if (r_age[w][w_touchSet] < w_touchOld) begin
                  r_age[w][w_touchSet] <= r_age[w][w_touchSet] + AGE_W'(1);
               end
            end
         end
      end
   end

   // Tag and data arrays need no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (w_doFill) begin
         r_tag[w_victim][w_fillIdx]  <= w_fillTag;
         r_data[w_victim][w_fillIdx] <= mem_rdata;
      end
   end

   assign mem_read  = r_memRead;
   assign mem_addr  = r_memAddr;
   assign mem_write = 1'b0;
   assign mem_wdata = '0;
   assign hit_cnt   = r_hitCnt;
   assign miss_cnt  = r_missCnt;

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc
// Scoreboarded bench for icache_assoc with default parameters. A reference
// model keeps, per set, the resident tags ordered from most to least recently
// used; reads push the expected word into a queue and a monitor compares it
// whenever the cache completes a read. A behavioural memory answers block
// reads after a fixed or random latency with address-derived data.
module tb_icache_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 4;
   localparam int CMAX = 65535;

   logic          clk;
   logic          proc_reset;
   logic          proc_read;
   logic          proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic          proc_stall;
   logic [31:0]   proc_rdata;
   logic          cache_flush;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
   logic [127:0]  mem_wdata;
   logic [15:0]   hit_cnt;
   logic [15:0]   miss_cnt;

   int checks = 0;
   int failures = 0;

   logic [31:0] sbQ [$];
   logic [29:0] lruQ [SETS][$];
   int modelHits = 0;
   int modelMisses = 0;

   int memLat = -1;
   int memWait = -1;
   bit memHold = 0;

   icache_assoc #(.NUM_SETS(SETS), .NUM_WAYS(WAYS), .CNT_W(16)) dut (
      .clk(clk),
      .proc_reset(proc_reset),
      .proc_read(proc_read),
      .proc_write(proc_write),
      .proc_addr(proc_addr),
      .proc_wdata(proc_wdata),
      .proc_stall(proc_stall),
      .proc_rdata(proc_rdata),
      .cache_flush(cache_flush),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .mem_wdata(mem_wdata),
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents are a fixed scramble of block address and word index.
   function automatic logic [31:0] memWord(input logic [27:0] b, input logic [1:0] k);
      logic [31:0] x;
      x = {4'h0, b} * 32'h9E3779B1;
      return x ^ {k, 28'h0, k} ^ 32'h13579BDF;
   endfunction

   function automatic logic [127:0] memBlock(input logic [27:0] b);
      logic [127:0] blk;
      for (int k = 0; k < 4; k++) begin
         blk[32*k +: 32] = memWord(b, 2'(k));
      end
      return blk;
   endfunction

   // Reference model: a read hits when its tag is resident in its set; the
   // tag then becomes MRU. A miss inserts the tag as MRU, dropping the LRU
   // tag when the set is full.
   function automatic bit modelAccess(input logic [29:0] a);
      int s;
      logic [29:0] t;
      s = int'(a[3:2]);
      t = a >> 4;
      for (int i = 0; i < lruQ[s].size(); i++) begin
         if (lruQ[s][i] == t) begin
            lruQ[s].delete(i);
            lruQ[s].push_front(t);
            if (modelHits < CMAX) modelHits++;
            return 1'b1;
         end
      end
      if (lruQ[s].size() == WAYS) void'(lruQ[s].pop_back());
      lruQ[s].push_front(t);
      if (modelMisses < CMAX) modelMisses++;
      return 1'b0;
   endfunction

   function automatic void modelFlush();
      for (int s = 0; s < SETS; s++) lruQ[s].delete();
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic checkCounters();
      checkOutput("hit_cnt", {16'h0, hit_cnt}, 32'(modelHits));
      checkOutput("miss_cnt", {16'h0, miss_cnt}, 32'(modelMisses));
   endtask

   // Memory responder: answers an outstanding block read with a one-cycle
   // mem_ready pulse after the configured (or random) number of cycles.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            memWait = -1;
         end else if (mem_read && !proc_reset && !memHold) begin
            if (memWait < 0) memWait = (memLat >= 0) ? memLat : int'($urandom_range(0, 3));
            if (memWait == 0) begin
               mem_ready = 1'b1;
               mem_rdata = memBlock(mem_addr);
            end else begin
               memWait--;
            end
         end else begin
            memWait = -1;
         end
      end
   end

   // Monitor: every completed read is checked against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!proc_reset && proc_read && !proc_stall) begin
            if (sbQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_read at %0t: got 0x%08h expected no completion", $time, proc_rdata);
            end else begin
               checkOutput("proc_rdata", proc_rdata, sbQ.pop_front());
            end
         end
      end
   end

   // Issue one read and follow it to completion, checking the handshake.
   task automatic applyStimulus(input logic [29:0] a);
      bit expHit;
      int n;
      expHit = modelAccess(a);
      proc_read  = 1'b1;
      proc_addr  = a;
      proc_write = 1'($urandom_range(0, 1));
      proc_wdata = $urandom();
      sbQ.push_back(memWord(a[29:2], a[1:0]));
      @(negedge clk);
      checkOutput("stall_on_request", {31'h0, proc_stall}, {31'h0, !expHit});
      if (expHit) begin
         checkOutput("mem_read_on_hit", {31'h0, mem_read}, 32'h0);
      end else begin
         @(negedge clk);
         checkOutput("mem_read_issued", {31'h0, mem_read}, 32'h1);
         checkOutput("mem_addr", {4'h0, mem_addr}, {4'h0, a[29:2]});
         n = 0;
         while (proc_stall && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (proc_stall) begin
            checks++;
            failures++;
            $display("[TB] FAIL miss_timeout at %0t: got stall=1 expected completion within 40 cycles", $time);
         end
      end
      @(posedge clk);
      #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      checkCounters();
   endtask

   task automatic flushCache(input bit withRead);
      cache_flush = 1'b1;
      proc_read   = withRead;
      proc_addr   = 30'($urandom_range(0, 63));
      @(negedge clk);
      checkOutput("flush_stall", {31'h0, proc_stall}, 32'h1);
      @(posedge clk);
      #1;
      cache_flush = 1'b0;
      proc_read   = 1'b0;
      modelFlush();
      @(negedge clk);
      checkOutput("post_flush_stall", {31'h0, proc_stall}, 32'h0);
      checkCounters();
      @(posedge clk);
      #1;
   endtask

   task automatic writeOnly(input logic [29:0] a, input int cycles);
      proc_write = 1'b1;
      proc_read  = 1'b0;
      proc_addr  = a;
      for (int i = 0; i < cycles; i++) begin
         proc_wdata = $urandom();
         @(negedge clk);
         checkOutput("write_stall", {31'h0, proc_stall}, 32'h0);
         checkOutput("write_mem_read", {31'h0, mem_read}, 32'h0);
         @(posedge clk);
         #1;
      end
      proc_write = 1'b0;
      checkCounters();
   endtask

   function automatic logic [29:0] randAddr();
      logic [25:0] tags [6];
      tags[0] = 26'h0;
      tags[1] = 26'h1;
      tags[2] = 26'h2;
      tags[3] = 26'h3;
      tags[4] = 26'h3FFFFFF;
      tags[5] = 26'h2AAAAAA;
      return {tags[$urandom_range(0, 5)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
   endfunction

   task automatic resetDut();
      proc_reset = 1'b1;
      proc_read = 1'b0;
      proc_write = 1'b0;
      cache_flush = 1'b0;
      @(negedge clk);
      checkOutput("reset_stall", {31'h0, proc_stall}, 32'h0);
      checkOutput("reset_rdata", proc_rdata, 32'h0);
      checkOutput("reset_mem_read", {31'h0, mem_read}, 32'h0);
      checkOutput("reset_mem_addr", {4'h0, mem_addr}, 32'h0);
      checkOutput("reset_hit_cnt", {16'h0, hit_cnt}, 32'h0);
      checkOutput("reset_miss_cnt", {16'h0, miss_cnt}, 32'h0);
      @(posedge clk);
      #1;
      proc_reset = 1'b0;
      modelFlush();
      modelHits = 0;
      modelMisses = 0;
   endtask

   initial begin
      int n;
      proc_reset = 1'b1;
      proc_read = 1'b0;
      proc_write = 1'b0;
      proc_addr = '0;
      proc_wdata = '0;
      cache_flush = 1'b0;
      @(posedge clk);
      #1;
      resetDut();

      // Directed sequence: cold miss, hit, LRU eviction, ignored writes.
      memLat = 3;
      applyStimulus(30'h00);
      applyStimulus(30'h03);
      memLat = -1;
      applyStimulus(30'h10);
      applyStimulus(30'h00);
      applyStimulus(30'h20);
      applyStimulus(30'h00);
      applyStimulus(30'h10);
      writeOnly(30'h55, 5);
      flushCache(1'b0);
      applyStimulus(30'h00);

      // Randomized mix of reads, flushes, write-only and idle cycles.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 19))
            0: flushCache(1'($urandom_range(0, 1)));
            1: writeOnly(randAddr(), int'($urandom_range(1, 3)));
            2: begin
               @(posedge clk);
               #1;
            end
            default: applyStimulus(randAddr());
         endcase
      end

      // Reset in the middle of a miss drops the request immediately.
      flushCache(1'b0);
      memHold = 1'b1;
      proc_read = 1'b1;
      proc_addr = 30'h44;
      n = 0;
      @(negedge clk);
      while (!mem_read && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("miss_pending", {31'h0, mem_read}, 32'h1);
      #2;
      proc_reset = 1'b1;
      #1;
      checkOutput("reset_mid_miss_mem_read", {31'h0, mem_read}, 32'h0);
      checkOutput("reset_mid_miss_stall", {31'h0, proc_stall}, 32'h0);
      proc_read = 1'b0;
      memHold = 1'b0;
      @(posedge clk);
      #1;
      resetDut();
      applyStimulus(30'h00);

      // Counter saturation: back-to-back hits beyond the counter range.
      for (int i = 0; i < 65541; i++) begin
         void'(modelAccess(30'h00));
         proc_read = 1'b1;
         proc_addr = 30'h00;
         sbQ.push_back(memWord(28'h0, 2'd0));
         @(posedge clk);
         #1;
      end
      proc_read = 1'b0;
      checkOutput("hit_cnt_saturated", {16'h0, hit_cnt}, 32'h0000FFFF);
      checkCounters();
      @(posedge clk);
      #1;

      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised read-only (instruction) cache that sits between the processor fetch port and the 128-bit block memory.
- Set-associative, with NUM_WAYS ways, NUM_SETS sets and 4 words of 32 bits per block.
- True-LRU replacement.
- Single-cycle whole-cache flush.
- Saturating hit and miss performance counters.
- Same processor and memory handshake as the existing direct-mapped cache, so it can be dropped in as a replacement.

Parameters:
NUM_SETS, 4, number of sets; power of two, 2..64; IDX_W = log2(NUM_SETS)
NUM_WAYS, 2, associativity; one of 1, 2, 4; AGE_W = max(1, log2(NUM_WAYS))
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
proc_reset  in  1  asynchronous active-high reset
proc_read  in  1  fetch request
proc_write  in  1  ignored (read-only cache)
proc_addr  in  30  word address
proc_wdata  in  32  ignored
proc_stall  out  1  processor must hold request while high
proc_rdata  out  32  fetched word
cache_flush  in  1  invalidate all lines
mem_read  out  1  block read request
mem_write  out  1  tied 0
mem_addr  out  28  block address
mem_rdata  in  128  block data; word k at bits [32k+31:32k]
mem_ready  in  1  memory has valid mem_rdata
mem_wdata  out  128  tied 0
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset: clk/proc_reset, asynchronous, active-high. While asserted, all valid bits = 0 and all LRU ages = way index. Outputs: proc_stall=0, proc_rdata=0, mem_read=0, mem_addr=0, hit_cnt=0, miss_cnt=0, state=S_IDLE. Assertion mid-miss drops mem_read immediately; the pending fill is discarded.
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[IDX_W+1:2]
  - tag = proc_addr[29:IDX_W+2]
- Per-way line state: valid, tag, 128-bit data, AGE_W-bit age (0 = MRU).
- Hit: valid && tag match in any way. Behaviour for more than one matching way is undefined; the design prevents it.
- S_IDLE, cache_flush=1:
  - All valid bits clear at the next edge.
  - proc_stall=1 for that cycle.
  - Flush has priority over proc_read.
  - Counters unchanged.
- S_IDLE, proc_read && hit (combinational):
  - proc_rdata = the hit word; proc_stall=0 in the same cycle (zero-latency hit).
  - Hit way's age becomes 0; every way in the set with an age lower than the old age increments.
  - hit_cnt increments, saturating at all-ones.
- S_IDLE, proc_read && miss:
  - proc_stall=1.
  - mem_addr <= proc_addr[29:2]; mem_read <= 1.
  - miss_cnt increments (once per miss, saturating).
  - Next state S_MEM_READ.
- S_IDLE, no request: proc_stall=0; proc_rdata holds its last value.
- S_MEM_READ:
  - mem_read and mem_addr are held until mem_ready.
  - proc_stall=1 while mem_ready=0.
  - cache_flush is ignored in this state; the requester holds it until it is sampled in S_IDLE.
  - proc_addr must be stable here (the processor is stalled).
- S_MEM_READ, mem_ready=1 (same cycle):
  - proc_rdata = mem_rdata word[offset]; proc_stall=0.
  - At the edge: victim way <= {valid=1, tag, mem_rdata}; victim age updated as MRU; mem_read <= 0; state <= S_IDLE.
  - Victim selection: lowest-index invalid way, otherwise the way with age NUM_WAYS-1.
- proc_write is ignored in every state: no stall, no state change. proc_read && proc_write is treated as a read.
- Latency: hit 0 extra cycles. Miss: 1 cycle to issue mem_read, plus memory latency; data is returned in the mem_ready cycle.
- NUM_WAYS=1 degenerates to direct-mapped with identical timing.

Test Plan:
Default parameters throughout (index = proc_addr[3:2], tag = proc_addr[29:4]); addresses are word addresses.
1. Reset, then proc_read at 0x00.
   -> proc_stall=1; next cycle mem_read=1, mem_addr=0x0000000.
   Memory answers after 3 cycles with mem_rdata = {D3,D2,D1,D0}.
   -> proc_rdata=D0, proc_stall=0 in the mem_ready cycle; miss_cnt=1.
2. Read 0x03 after test 1.
   -> hit, proc_rdata=D3 in the same cycle, mem_read stays 0, hit_cnt=1.
3. Read 0x10 (set 0, tag 1): miss fills way1. Read 0x00: hit, making way1 the LRU. Read 0x20 (tag 2).
   -> miss evicts the tag-1 line. Then read 0x00 -> hit; read 0x10 -> miss, mem_addr=0x0000004.
4. Hold proc_write=1 with proc_addr=0x55 for 5 cycles.
   -> proc_stall=0, mem_read=0, counters unchanged.
5. Pulse cache_flush in S_IDLE.
   -> proc_stall=1 for 1 cycle; a subsequent read of 0x00 misses; miss_cnt increments.
6. Assert proc_reset while in S_MEM_READ.
   -> mem_read=0 and proc_stall=0 immediately. After release, read 0x00 misses. Counter test: drive 2^16+5 hits -> hit_cnt=0xFFFF (saturated).
